// File: rtl/muldiv_unit_if.sv
// Command/result bundle between the ID/EX stage and the iterative multiply/divide unit.
// The master drives commands and MFHI/MFLO requests; the slave is the unit with HI/LO.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_op1;
  logic [WIDTH-1:0] i_op2;
  logic             i_rd_hi;
  logic             i_rd_lo;
  logic             i_flush;
  logic [WIDTH-1:0] o_rdata;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  logic             o_busy;
  logic             o_stall;
  logic             o_done;
  logic             o_div_zero;

  modport master (
    output i_op, i_op1, i_op2, i_rd_hi, i_rd_lo, i_flush,
    input  o_rdata, o_hi, o_lo, o_busy, o_stall, o_done, o_div_zero
  );

  modport slave (
    input  i_op, i_op1, i_op2, i_rd_hi, i_rd_lo, i_flush,
    output o_rdata, o_hi, o_lo, o_busy, o_stall, o_done, o_div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// Operates on magnitudes over WIDTH cycles, then sign-corrects in a single FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          i_clk,
  input logic          i_rst,
  muldiv_unit_if.slave bus
);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opb_q;
  logic [5:0]           count_q;
  logic                 is_div_q, neg_res_q, neg_rem_q, zero_div_q;
  logic                 done_q, div_zero_q;

  logic                 is_signed, is_div, start, last_step;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [WIDTH-1:0]     quot, rem;

  assign is_signed = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);
  assign is_div    = (bus.i_op == OP_DIV)  || (bus.i_op == OP_DIVU);
  assign start     = (state_q == IDLE) && !bus.i_flush &&
                     ((bus.i_op == OP_MULT) || (bus.i_op == OP_MULTU) || is_div);
  assign last_step = (count_q == 6'(WIDTH - 1));

  assign mag1 = (is_signed && bus.i_op1[WIDTH-1]) ? -bus.i_op1 : bus.i_op1;
  assign mag2 = (is_signed && bus.i_op2[WIDTH-1]) ? -bus.i_op2 : bus.i_op2;

  // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quot = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (bus.i_flush) state_d = IDLE;
               else if (last_step) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hi_q       <= '0;
      lo_q       <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      count_q    <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Divide iterates on the dividend in acc; multiply shifts the multiplier out of it
            acc_q      <= {{WIDTH{1'b0}}, is_div ? mag1 : mag2};
            opb_q      <= is_div ? mag2 : mag1;
            count_q    <= '0;
            is_div_q   <= is_div;
            neg_res_q  <= is_signed && (bus.i_op1[WIDTH-1] ^ bus.i_op2[WIDTH-1]);
            neg_rem_q  <= is_signed && bus.i_op1[WIDTH-1];
            zero_div_q <= (bus.i_op2 == '0);
          end else if (!bus.i_flush && bus.i_op == OP_MTHI) begin
            hi_q <= bus.i_op1;
          end else if (!bus.i_flush && bus.i_op == OP_MTLO) begin
            lo_q <= bus.i_op1;
          end
        end
        CALC: begin
          if (!bus.i_flush) begin
            acc_q   <= is_div_q ? div_next : mul_next;
            count_q <= count_q + 6'd1;
          end
        end
        FIX: begin
          if (!bus.i_flush) begin
            done_q <= 1'b1;
            if (is_div_q && zero_div_q) begin
              // Remainder equals the dividend magnitude; rem restores the original operand
              hi_q       <= rem;
              lo_q       <= '1;
              div_zero_q <= 1'b1;
            end else if (is_div_q) begin
              hi_q <= rem;
              lo_q <= quot;
            end else begin
              hi_q <= prod[2*WIDTH-1:WIDTH];
              lo_q <= prod[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_hi       = hi_q;
  assign bus.o_lo       = lo_q;
  assign bus.o_rdata    = bus.i_rd_hi ? hi_q : lo_q;
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_stall    = bus.o_busy &&
                          (((bus.i_op != 3'b000) && (bus.i_op != 3'b111)) || bus.i_rd_hi || bus.i_rd_lo);
  assign bus.o_done     = done_q;
  assign bus.o_div_zero = div_zero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO are queued at issue and popped by a
// monitor on every o_done pulse; stall, flush and reset behaviour are checked inline.
module tb_muldiv_unit;
  localparam int WIDTH = 32;
  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();
  muldiv_unit #(.WIDTH(WIDTH)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.o_done) begin
        if (sb_q.size() == 0) begin
          check_output("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_output("done_hi", bus.o_hi, e.hi);
          check_output("done_lo", bus.o_lo, e.lo);
          check_output("done_div_zero", bus.o_div_zero, e.dz);
        end
      end
    end
  end

  // Presents a command for one accepting edge, then scrambles the operand buses
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.i_op  = op;
    bus.i_op1 = a;
    bus.i_op2 = b;
    @(posedge clk); #1;
    bus.i_op  = OP_NONE;
    bus.i_op1 = $urandom;
    bus.i_op2 = $urandom;
  endtask

  task automatic wait_idle(output int cycles);
    logic idle_seen;
    idle_seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 100 && !idle_seen; i++) begin
      @(negedge clk);
      if (!bus.o_busy) idle_seen = 1'b1;
      else cycles++;
    end
    if (!idle_seen) check_output("busy_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                        output int cycles);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz;
    sb_q.push_back(e);
    apply_stimulus(op, a, b);
    wait_idle(cycles);
  endtask

  initial begin
    int cycles;
    int stall_low;
    int done_seen;
    logic ok;

    rst = 1'b1;
    bus.i_op = OP_NONE; bus.i_op1 = '0; bus.i_op2 = '0;
    bus.i_rd_hi = 1'b0; bus.i_rd_lo = 1'b0; bus.i_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset_hi", bus.o_hi, 32'h0);
    check_output("reset_lo", bus.o_lo, 32'h0);
    check_output("reset_busy", bus.o_busy, 1'b0);
    check_output("reset_done", bus.o_done, 1'b0);

    run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, cycles);
    check_output("mult_busy_cycles", cycles, 33);
    check_output("mult_done_now", bus.o_done, 1'b1);
    @(negedge clk);
    check_output("mult_done_single", bus.o_done, 1'b0);

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, cycles);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, cycles);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, cycles);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, cycles);
    run_op(OP_DIV, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 1'b1, cycles);
    check_output("divzero_busy_cycles", cycles, 33);

    // MFLO and MTLO arrive while a DIV 20/3 is in flight
    begin
      exp_t e;
      e.hi = 32'd2; e.lo = 32'd6; e.dz = 1'b0;
      sb_q.push_back(e);
    end
    apply_stimulus(OP_DIV, 32'd20, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    bus.i_rd_lo = 1'b1;
    bus.i_op    = OP_MTLO;
    bus.i_op1   = 32'hDEAD0000;
    @(negedge clk);
    check_output("mtlo_stall", bus.o_stall, 1'b1);
    @(posedge clk); #1;
    bus.i_op = OP_NONE;
    @(negedge clk);
    check_output("mtlo_ignored", bus.o_lo, 32'hFFFFFFFF);
    stall_low = 0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (!bus.o_busy) ok = 1'b1;
      else begin
        if (!bus.o_stall) stall_low++;
        @(negedge clk);
      end
    end
    if (!ok) check_output("mflo_timeout", 64'd1, 64'd0);
    check_output("mflo_stall_held", stall_low, 0);
    check_output("mflo_done_no_stall", bus.o_stall, 1'b0);
    check_output("mflo_rdata", bus.o_rdata, 32'd6);
    #1 bus.i_rd_lo = 1'b0;

    // Flush in the middle of a MULT leaves HI/LO alone
    apply_stimulus(OP_MTHI, 32'h12345678, 32'h0);
    apply_stimulus(OP_MTLO, 32'h12345678, 32'h0);
    @(negedge clk);
    check_output("mthi_write", bus.o_hi, 32'h12345678);
    check_output("mtlo_write", bus.o_lo, 32'h12345678);
    apply_stimulus(OP_MULT, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #1 bus.i_flush = 1'b1;
    @(posedge clk);
    #1 bus.i_flush = 1'b0;
    @(negedge clk);
    check_output("flush_busy", bus.o_busy, 1'b0);
    check_output("flush_hi", bus.o_hi, 32'h12345678);
    check_output("flush_lo", bus.o_lo, 32'h12345678);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done) done_seen++;
    end
    check_output("flush_no_done", done_seen, 0);

    apply_stimulus(OP_MTHI, 32'h000000AA, 32'h0);
    check_output("pre_flush_mthi_hi", bus.o_hi, 32'h000000AA);
    @(posedge clk); #1;
    bus.i_op = OP_MTHI; bus.i_op1 = 32'h00000055; bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_op = OP_NONE; bus.i_flush = 1'b0;
    @(negedge clk);
    check_output("flush_mthi_hi", bus.o_hi, 32'h000000AA);

    // Reset mid-operation discards the result; a fresh MULTU still works
    apply_stimulus(OP_MULT, 32'd9, 32'd9);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("midrst_hi", bus.o_hi, 32'h0);
    check_output("midrst_lo", bus.o_lo, 32'h0);
    check_output("midrst_busy", bus.o_busy, 1'b0);
    run_op(OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, cycles);
    check_output("multu_after_rst_cycles", cycles, 33);

    repeat (3) @(negedge clk);
    check_output("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
